poca_sequencer_v2: RTL and testbench
====================================

POCA_SEQUENCER_V2 -- requirements
Module: poca_sequencer_v2

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
  MULT_SIZE 283: ECC point/key width
  HASH_SIZE 256: hash width
  SEED_SIZE 128: challenge seed width
  CYCLE_SIZE 32: challenge cycle-count width
  TIMEOUT_W 16: per-stage timeout counter width
  CNT_W 16: session counter width
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
  clk in 1: single clock, rising edge
  rst in 1: asynchronous, active-low reset
  go in 1: session request (level)
  mode in 1: 0 = response only; 1 = response plus HSM key exchange
  seed in SEED_SIZE: challenge seed
  cycle in CYCLE_SIZE: challenge cycle count
  timeout_limit in TIMEOUT_W: stage timeout in cycles; 0 disables
  seed_q out SEED_SIZE: seed latched at session start
  cycle_q out CYCLE_SIZE: cycle latched at session start
  trng_start/pk_start/sign_start/hash_start/ss_start out 1 each: engine start pulses
  trng_done/pk_done/sign_done/hash_done/ss_done in 1 each: engine done strobes
  public_key_in in MULT_SIZE: chip public key from ECC engine
  hash_in in HASH_SIZE: hash of public key
  public_key_hsm_received in 1: HSM key valid (level)
  response out MULT_SIZE+HASH_SIZE: {public key, hash}
  response_ready, secret_key_ready, busy, error out 1 each: status
  err_code out 3: state id of the stage that timed out
  session_count out CNT_W: completed sessions

Function
REQ-003 SHALL implement states IDLE=0, TRNG=1, PUBKEY=2, SIGN=3, HASH=4, WAIT_HSM=5, SECRET=6, DONE=7, plus ERROR (encoded distinctly; err_code uses 1-6).
REQ-004 In IDLE with go=1, SHALL latch seed/cycle into seed_q/cycle_q and enter TRNG next cycle; go ignored outside IDLE.
REQ-005 On the first cycle in each engine state (TRNG, PUBKEY, SIGN, HASH, SECRET), SHALL assert the matching *_start for exactly one cycle.
REQ-006 SHALL ignore done strobes in the start cycle; a done in any later cycle advances TRNG->PUBKEY->SIGN->HASH next cycle.
REQ-007 When HASH accepts hash_done, SHALL capture response={public_key_in,hash_in} and assert response_ready on the next cycle, held until IDLE.
REQ-008 After HASH: mode=0 -> DONE; mode=1 -> WAIT_HSM. mode SHALL be sampled at go acceptance.
REQ-009 WAIT_HSM SHALL move to SECRET on the first cycle public_key_hsm_received=1.
REQ-010 SECRET accepting ss_done SHALL enter DONE and set secret_key_ready, held until IDLE.
REQ-011 The timeout counter SHALL clear on every state entry and increment each cycle in TRNG..SECRET; when it equals nonzero timeout_limit without a done/HSM event, SHALL enter ERROR with error=1 and err_code=state id.
REQ-012 A done arriving in the same cycle the timeout matches SHALL win (normal advance, no error).
REQ-013 DONE and ERROR SHALL hold all status outputs until go=0, then return to IDLE; outputs clear on IDLE entry, except response (held) and session_count.
REQ-014 session_count SHALL increment by 1 on DONE entry, wrapping from 2^CNT_W-1 to 0; ERROR does not increment it.
REQ-015 busy SHALL be 1 in every state except IDLE, DONE and ERROR.
REQ-016 Unexpected done strobes from non-active engines SHALL be ignored.

Reset
REQ-017 rst=0 SHALL immediately force IDLE, zero all outputs, counters, seed_q, cycle_q and response, including mid-session; start pulses deassert asynchronously.
REQ-018 After rst release, the first go sampled high SHALL start a session normally.

Verification
REQ-019 mode=0, seed=128'h60b998885e75315b3866889c53e92dfe, cycle=32'h1F4, each done one cycle after start -> one start pulse per engine in order; response_ready 1 cycle after hash_done; response={public_key_in,hash_in}; session_count=1.
REQ-020 mode=1, public_key_hsm_received raised 200 ns after response_ready, ss_done 3 cycles after ss_start -> secret_key_ready=1, busy=0, session_count=1.
REQ-021 timeout_limit=10, sign_done withheld -> error=1 and err_code=3 exactly 10 cycles after SIGN entry; no hash_start; cleared once go=0.
REQ-022 timeout_limit=5, pk_done coinciding with the timeout cycle -> no error; SIGN entered.
REQ-023 rst asserted mid-HASH -> all outputs 0 immediately; re-run with go completes normally.
REQ-024 CNT_W=2, five back-to-back sessions -> session_count 1,2,3,0,1.

Source files
------------

// File: rtl/poca_sequencer_v2.sv
// PoCA session sequencer: steps TRNG -> public key -> sign -> hash engines,
// optionally waits for the HSM key and runs the shared-secret engine, with a
// per-stage timeout that parks the FSM in ERROR until go drops.
module poca_sequencer_v2 #(
   parameter int MULT_SIZE  = 283,
   parameter int HASH_SIZE  = 256,
   parameter int SEED_SIZE  = 128,
   parameter int CYCLE_SIZE = 32,
   parameter int TIMEOUT_W  = 16,
   parameter int CNT_W      = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           go,
   input  logic                           mode,
   input  logic [SEED_SIZE-1:0]           seed,
   input  logic [CYCLE_SIZE-1:0]          cycle,
   input  logic [TIMEOUT_W-1:0]           timeout_limit,
   output logic [SEED_SIZE-1:0]           seed_q,
   output logic [CYCLE_SIZE-1:0]          cycle_q,
   output logic                           trng_start,
   output logic                           pk_start,
   output logic                           sign_start,
   output logic                           hash_start,
   output logic                           ss_start,
   input  logic                           trng_done,
   input  logic                           pk_done,
   input  logic                           sign_done,
   input  logic                           hash_done,
   input  logic                           ss_done,
   input  logic [MULT_SIZE-1:0]           public_key_in,
   input  logic [HASH_SIZE-1:0]           hash_in,
   input  logic                           public_key_hsm_received,
   output logic [MULT_SIZE+HASH_SIZE-1:0] response,
   output logic                           response_ready,
   output logic                           secret_key_ready,
   output logic                           busy,
   output logic                           error,
   output logic [2:0]                     err_code,
   output logic [CNT_W-1:0]               session_count
);
   typedef enum logic [3:0] {
      IDLE = 4'd0, TRNG = 4'd1, PUBKEY = 4'd2, SIGN = 4'd3, HASH = 4'd4,
      WAIT_HSM = 4'd5, SECRET = 4'd6, DONE = 4'd7, ERROR = 4'd8
   } state_t;

   state_t                 state, state_n;
   logic                   first;     // first cycle after a state change
   logic                   mode_q;
   logic [TIMEOUT_W-1:0]   tcnt, tcnt_inc;
   logic                   timed, advance, expired, entering;
   logic [2:0]             state_id;

   assign state_id = state[2:0];
   assign tcnt_inc = tcnt + 1'b1;
   assign entering = (state_n != state);

   // Next state, start pulses and busy; a done/HSM event beats a same-cycle timeout
   always_comb begin
      state_n    = state;
      advance    = 1'b0;
      timed      = 1'b0;
      trng_start = 1'b0;
      pk_start   = 1'b0;
      sign_start = 1'b0;
      hash_start = 1'b0;
      ss_start   = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (go) state_n = TRNG;
         end
         TRNG: begin
            timed = 1'b1; trng_start = first; advance = trng_done & ~first;
            if (advance) state_n = PUBKEY;
         end
         PUBKEY: begin
            timed = 1'b1; pk_start = first; advance = pk_done & ~first;
            if (advance) state_n = SIGN;
         end
         SIGN: begin
            timed = 1'b1; sign_start = first; advance = sign_done & ~first;
            if (advance) state_n = HASH;
         end
         HASH: begin
            timed = 1'b1; hash_start = first; advance = hash_done & ~first;
            if (advance) state_n = mode_q ? WAIT_HSM : DONE;
         end
         WAIT_HSM: begin
            timed = 1'b1; advance = public_key_hsm_received;
            if (advance) state_n = SECRET;
         end
         SECRET: begin
            timed = 1'b1; ss_start = first; advance = ss_done & ~first;
            if (advance) state_n = DONE;
         end
         DONE, ERROR: begin
            busy = 1'b0;
            if (!go) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      // tcnt counts cycles already spent here, so tcnt+1 is the current cycle's ordinal
      expired = timed && (timeout_limit != '0) && (tcnt_inc == timeout_limit);
      if (expired && !advance) state_n = ERROR;
   end

   // State register, entry flag and per-stage timeout counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         first <= 1'b0;
         tcnt  <= '0;
      end else begin
         state <= state_n;
         first <= entering;
         if (entering)   tcnt <= '0;
         else if (timed) tcnt <= tcnt_inc;
      end
   end

   // Session data capture and sticky status flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seed_q           <= '0;
         cycle_q          <= '0;
         mode_q           <= 1'b0;
         response         <= '0;
         response_ready   <= 1'b0;
         secret_key_ready <= 1'b0;
         error            <= 1'b0;
         err_code         <= '0;
         session_count    <= '0;
      end else begin
         if (state == IDLE && go) begin
            seed_q  <= seed;
            cycle_q <= cycle;
            mode_q  <= mode;
         end
         if (state == HASH && advance) begin
            response       <= {public_key_in, hash_in};
            response_ready <= 1'b1;
         end
         if (state == SECRET && advance) secret_key_ready <= 1'b1;
         if (entering && state_n == DONE) session_count <= session_count + 1'b1;
         if (entering && state_n == ERROR) begin
            error    <= 1'b1;
            err_code <= state_id;
         end
         // response itself stays visible after the session closes
         if (entering && state_n == IDLE) begin
            response_ready   <= 1'b0;
            secret_key_ready <= 1'b0;
            error            <= 1'b0;
            err_code         <= '0;
         end
      end
   end
endmodule

// File: tb/tb_poca_sequencer_v2.sv
// Bench for poca_sequencer_v2: plays the five engines and the HSM, and checks
// start order, handshake latency, timeouts, reset and session counting.
module tb_poca_sequencer_v2;
   localparam int MS = 283, HS = 256, SS = 128, CS = 32, TW = 16, CW = 2;

   logic            clk = 1'b0, rst = 1'b0, go = 1'b0, mode = 1'b0;
   logic [SS-1:0]   seed = '0;
   logic [CS-1:0]   cycle = '0;
   logic [TW-1:0]   timeout_limit = '0;
   logic [SS-1:0]   seed_q;
   logic [CS-1:0]   cycle_q;
   logic            trng_start, pk_start, sign_start, hash_start, ss_start;
   logic [4:0]      dn = '0;
   logic [MS-1:0]   public_key_in = '0;
   logic [HS-1:0]   hash_in = '0;
   logic            public_key_hsm_received = 1'b0;
   logic [MS+HS-1:0] response;
   logic            response_ready, secret_key_ready, busy, error;
   logic [2:0]      err_code;
   logic [CW-1:0]   session_count;
   logic [4:0]      st;

   int total = 0, bad = 0, sessions = 0;

   assign st = {ss_start, hash_start, sign_start, pk_start, trng_start};

   always #5 clk = ~clk;

   poca_sequencer_v2 #(.MULT_SIZE(MS), .HASH_SIZE(HS), .SEED_SIZE(SS), .CYCLE_SIZE(CS),
                       .TIMEOUT_W(TW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .go(go), .mode(mode), .seed(seed), .cycle(cycle),
      .timeout_limit(timeout_limit), .seed_q(seed_q), .cycle_q(cycle_q),
      .trng_start(trng_start), .pk_start(pk_start), .sign_start(sign_start),
      .hash_start(hash_start), .ss_start(ss_start),
      .trng_done(dn[0]), .pk_done(dn[1]), .sign_done(dn[2]), .hash_done(dn[3]), .ss_done(dn[4]),
      .public_key_in(public_key_in), .hash_in(hash_in),
      .public_key_hsm_received(public_key_hsm_received),
      .response(response), .response_ready(response_ready), .secret_key_ready(secret_key_ready),
      .busy(busy), .error(error), .err_code(err_code), .session_count(session_count)
   );

   task automatic cyc();
      @(negedge clk);
   endtask

   function automatic logic [511:0] rnd512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Stall in stage sid: error must appear exactly 'limit' cycles after entry
   task automatic expect_timeout(input int sid, input int limit);
      bit early = 1'b0;
      dn = '0;
      for (int k = 1; k < limit; k++) begin
         cyc();
         if (error !== 1'b0 || st !== 5'd0 || busy !== 1'b1) early = 1'b1;
      end
      total++;
      if (early) begin
         bad++; $display("FAIL timeout_early stage=%0d: error/start/busy changed before %0d cycles", sid, limit);
      end
      cyc();
      total++;
      if (error !== 1'b1 || err_code !== 3'(sid) || busy !== 1'b0 || st !== 5'd0) begin
         bad++; $display("FAIL timeout_fire stage=%0d: error=%b err_code=%0d busy=%b starts=%b want 1/%0d/0/0",
                         sid, error, err_code, busy, st, sid);
      end
      repeat (2) cyc();
      total++;
      if (error !== 1'b1 || err_code !== 3'(sid)) begin
         bad++; $display("FAIL timeout_hold stage=%0d: error=%b err_code=%0d", sid, error, err_code);
      end
      go = 1'b0;
      cyc();
      total++;
      if (error !== 1'b0 || err_code !== 3'd0 || busy !== 1'b0 || session_count !== CW'(sessions % 4)) begin
         bad++; $display("FAIL timeout_clear: error=%b err_code=%0d busy=%b count=%0d want 0/0/0/%0d",
                         error, err_code, busy, session_count, sessions % 4);
      end
   endtask

   // One session; stall = state id whose event is withheld (0 none), rst_at = engine index to reset at (-1 none)
   task automatic run_session(input bit m, input logic [SS-1:0] s_in, input logic [CS-1:0] c_in,
                              input int lat, input int hsm_lat, input int stall, input int limit,
                              input int rst_at);
      logic [MS-1:0] pk;
      logic [HS-1:0] h;
      int  w, eb;
      bit  pulse_bad, rr_early;
      pk = MS'(rnd512());
      h  = HS'(rnd512());
      seed = s_in; cycle = c_in; mode = m; timeout_limit = TW'(limit);
      public_key_in = pk; hash_in = h;
      go = 1'b1;
      cyc();
      // these must be ignored once the session is running
      seed = SS'(rnd512()); cycle = $urandom; mode = ~m;
      for (int e = 0; e < 6; e++) begin
         if (e == 4) begin
            if (!m) break;
            total++;
            if (busy !== 1'b1 || st !== 5'd0) begin
               bad++; $display("FAIL wait_hsm_entry: busy=%b starts=%b want 1/00000", busy, st);
            end
            if (stall == 5) begin expect_timeout(5, limit); return; end
            repeat (hsm_lat) cyc();
            public_key_hsm_received = 1'b1;
            cyc();
            public_key_hsm_received = 1'b0;
            continue;
         end
         eb = (e < 4) ? e : 4;
         w = 0;
         while (st === 5'd0 && w < 40) begin cyc(); w++; end
         total++;
         if (st !== (5'd1 << eb) || w != 0) begin
            bad++; $display("FAIL start_order stage=%0d: starts=%b after %0d cycles want %b after 0",
                            e + 1, st, w, 5'd1 << eb);
         end
         if (e == 0) begin
            total++;
            if (seed_q !== s_in || cycle_q !== c_in) begin
               bad++; $display("FAIL latch: seed_q=%h cycle_q=%h want %h %h", seed_q, cycle_q, s_in, c_in);
            end
         end
         if (e == rst_at) begin
            rst = 1'b0;
            #1;
            total++;
            if ({st, busy, response_ready, secret_key_ready, error, err_code, session_count} !== '0 ||
                seed_q !== '0 || cycle_q !== '0 || response !== '0) begin
               bad++; $display("FAIL reset_mid: starts=%b busy=%b rr=%b err=%b cnt=%0d seed_q=%h want all 0",
                               st, busy, response_ready, error, session_count, seed_q);
            end
            go = 1'b0; dn = '0;
            cyc(); cyc();
            rst = 1'b1;
            sessions = 0;
            cyc();
            return;
         end
         if (stall == e + 1) begin expect_timeout(e + 1, limit); return; end
         pulse_bad = 1'b0;
         rr_early  = 1'b0;
         for (int k = 0; k <= lat; k++) begin
            if (k > 0 && st !== 5'd0) pulse_bad = 1'b1;
            dn = 5'($urandom) & ~(5'd1 << eb);
            if (k == lat || (k == 0 && $urandom_range(0, 1) == 1)) dn[eb] = 1'b1;
            if (e == 3 && response_ready !== 1'b0) rr_early = 1'b1;
            cyc();
         end
         dn = '0;
         total++;
         if (pulse_bad || error !== 1'b0) begin
            bad++; $display("FAIL start_pulse stage=%0d: extra start or error=%b during handshake", e + 1, error);
         end
         if (e == 3) begin
            total++;
            if (rr_early || response_ready !== 1'b1 || response !== {pk, h}) begin
               bad++; $display("FAIL response: early=%b rr=%b resp=%h want rr=1 resp=%h",
                               rr_early, response_ready, response, {pk, h});
            end
         end
      end
      sessions++;
      total++;
      if (busy !== 1'b0 || session_count !== CW'(sessions % 4) || secret_key_ready !== m ||
          response_ready !== 1'b1 || error !== 1'b0) begin
         bad++; $display("FAIL done_state: busy=%b cnt=%0d skr=%b rr=%b err=%b want 0/%0d/%b/1/0",
                         busy, session_count, secret_key_ready, response_ready, error, sessions % 4, m);
      end
      repeat ($urandom_range(0, 3)) cyc();
      total++;
      if (busy !== 1'b0 || response_ready !== 1'b1 || secret_key_ready !== m || st !== 5'd0) begin
         bad++; $display("FAIL done_hold: busy=%b rr=%b skr=%b starts=%b", busy, response_ready, secret_key_ready, st);
      end
      go = 1'b0;
      cyc();
      total++;
      if (response_ready !== 1'b0 || secret_key_ready !== 1'b0 || busy !== 1'b0 ||
          response !== {pk, h} || session_count !== CW'(sessions % 4)) begin
         bad++; $display("FAIL idle_return: rr=%b skr=%b busy=%b cnt=%0d resp_held=%b",
                         response_ready, secret_key_ready, busy, session_count, response === {pk, h});
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) cyc();
      total++;
      if ({st, busy, response_ready, secret_key_ready, error, err_code, session_count} !== '0 ||
          seed_q !== '0 || cycle_q !== '0 || response !== '0) begin
         bad++; $display("FAIL reset_state: starts=%b busy=%b rr=%b err=%b cnt=%0d want all 0",
                         st, busy, response_ready, error, session_count);
      end
      rst = 1'b1;
      cyc();
   endtask

   task automatic test_basic();
      run_session(1'b0, 128'h60b998885e75315b3866889c53e92dfe, 32'h1F4, 1, 0, 0, 0, -1);
   endtask

   task automatic test_hsm();
      run_session(1'b1, SS'(rnd512()), $urandom, 3, 20, 0, 0, -1);
   endtask

   task automatic test_timeout();
      run_session(1'b0, SS'(rnd512()), $urandom, 1, 0, 3, 10, -1);
      run_session(1'b0, SS'(rnd512()), $urandom, 1, 0, 1, 1, -1);
      run_session(1'b1, SS'(rnd512()), $urandom, 2, 0, 5, 7, -1);
      run_session(1'b1, SS'(rnd512()), $urandom, 2, 1, 6, 3, -1);
   endtask

   task automatic test_coincide();
      run_session(1'b0, SS'(rnd512()), $urandom, 4, 0, 0, 5, -1);
      run_session(1'b1, SS'(rnd512()), $urandom, 2, 4, 0, 5, -1);
   endtask

   task automatic test_reset_mid();
      run_session(1'b1, SS'(rnd512()), $urandom, 2, 0, 0, 0, 3);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 5; i++) run_session(i[0], SS'(rnd512()), $urandom, 1, 0, 0, 0, -1);
   endtask

   task automatic test_random();
      bit m;
      int lat, limit, hsm, stall;
      for (int i = 0; i < 20; i++) begin
         m     = 1'($urandom_range(0, 1));
         lat   = $urandom_range(1, 6);
         limit = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(lat + 1, 12);
         stall = 0;
         if ($urandom_range(0, 3) == 0) begin
            stall = $urandom_range(1, m ? 6 : 4);
            if (limit == 0) limit = lat + 1;
         end
         hsm = (limit == 0) ? $urandom_range(0, 15) : $urandom_range(0, limit - 1);
         run_session(m, SS'(rnd512()), $urandom, lat, hsm, stall, limit, -1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_hsm();
      test_timeout();
      test_coincide();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
